// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter and fixed-latency sequencer for one shared memory port.
// Port 0 is read-only fetch, port 1 is read/write data; one transaction in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] addr0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata,
    output logic             mux_sel,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] CntInit = CntW'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              gnt;

    // grant_q doubles as last_grant: on a tie, serve the port that was not served last.
    assign gnt = req1 & (~req0 | ~grant_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    grant_d = gnt;
                    addr_d  = gnt ? addr1 : addr0;
                    wdata_d = gnt ? wdata1 : '0;
                    we_d    = we1 & gnt;
                    cnt_d   = CntInit;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode registered state only, so they carry no combinational glitches.
    assign mem_en    = (state_q == StBusy);
    assign mem_we    = (state_q == StBusy) & we_q;
    assign ack0      = (state_q == StResp) & ~grant_q;
    assign ack1      = (state_q == StResp) & grant_q;
    assign mux_sel   = grant_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-timing reference model; LAT=2 and LAT=1 builds share one stimulus.
module tb_mem_port_arbiter;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [W-1:0] addr0 = '0, addr1 = '0, wdata1 = '0, mem_rdata = '0;

    logic         ack0_a, ack1_a, sel_a, en_a, we_a;
    logic [W-1:0] rdata_a, addr_a, wdata_a;
    logic         ack0_b, ack1_b, sel_b, en_b, we_b;
    logic [W-1:0] rdata_b, addr_b, wdata_b;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(W), .LAT(2)) u_dut_lat2 (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0_a), .ack1(ack1_a), .rdata(rdata_a), .mux_sel(sel_a),
        .mem_en(en_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.WIDTH(W), .LAT(1)) u_dut_lat1 (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b), .mux_sel(sel_b),
        .mem_en(en_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_rdata(mem_rdata)
    );

    bit           use_b = 1'b0;
    logic         o_ack0, o_ack1, o_sel, o_en, o_we;
    logic [W-1:0] o_rdata, o_addr, o_wdata;

    always_comb begin
        o_ack0  = use_b ? ack0_b  : ack0_a;
        o_ack1  = use_b ? ack1_b  : ack1_a;
        o_sel   = use_b ? sel_b   : sel_a;
        o_en    = use_b ? en_b    : en_a;
        o_we    = use_b ? we_b    : we_a;
        o_rdata = use_b ? rdata_b : rdata_a;
        o_addr  = use_b ? addr_b  : addr_a;
        o_wdata = use_b ? wdata_b : wdata_a;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: a transaction is described by its phase, the number of edges since grant.
    int           lat = 2;
    int           ph = 0;
    bit           act = 1'b0, own = 1'b0, sel_e = 1'b0, we_l = 1'b0;
    logic [W-1:0] addr_l = '0, wdata_l = '0, rdata_e = '0;
    bit           hold0 = 1'b0, hold1 = 1'b0, rnd = 1'b0;
    int           cyc = 0;
    int           ack_p[$];
    int           ack_t[$];

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] memfn(input logic [W-1:0] a);
        if (a == 64'h100) return 64'hDEAD;
        return {a[31:0] ^ 32'hC0DE_1234, ~a[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        ack_p.delete();
        ack_t.delete();
        cyc = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_en"}, 64'(o_en), 64'(0));
        chk({tag, "_mem_we"}, 64'(o_we), 64'(0));
        chk({tag, "_ack0"}, 64'(o_ack0), 64'(0));
        chk({tag, "_ack1"}, 64'(o_ack1), 64'(0));
        chk({tag, "_mux_sel"}, 64'(o_sel), 64'(0));
        chk({tag, "_mem_addr"}, o_addr, '0);
        chk({tag, "_mem_wdata"}, o_wdata, '0);
        chk({tag, "_rdata"}, o_rdata, '0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        act = 1'b0; sel_e = 1'b0; we_l = 1'b0;
        addr_l = '0; wdata_l = '0; rdata_e = '0;
        chk_reset_outputs("rst_async");
        @(negedge clk);
        chk_reset_outputs("rst_held");
        reset = 1'b0;
    endtask

    task automatic cycle();
        bit a0, a1, en_e, lastb, ack0_e, ack1_e;
        @(posedge clk);
        cyc++;
        a0 = act && ph == lat + 1 && !own;
        a1 = act && ph == lat + 1 && own;
        if (act) begin
            if (ph == lat && !we_l) rdata_e = memfn(addr_l);
            if (ph == lat + 1) act = 1'b0;
            else ph++;
        end else if (req0 || req1) begin
            own     = req1 && (!req0 || !sel_e);
            sel_e   = own;
            act     = 1'b1;
            ph      = 1;
            addr_l  = own ? addr1 : addr0;
            wdata_l = own ? wdata1 : '0;
            we_l    = own && we1;
        end
        #1;
        if (a0) begin
            if (hold0) addr0 = rnd64();
            else req0 = 1'b0;
        end
        if (a1) begin
            if (hold1) begin
                addr1  = rnd64();
                wdata1 = rnd64();
            end else begin
                req1 = 1'b0;
            end
        end
        if (rnd) begin
            if (!req0) begin
                if ($urandom_range(3) == 0) begin
                    req0  = 1'b1;
                    addr0 = rnd64();
                end
            end else if (!(act && !own) && $urandom_range(15) == 0) begin
                req0 = 1'b0;
            end
            if (!req1) begin
                if ($urandom_range(3) == 0) begin
                    req1   = 1'b1;
                    we1    = 1'($urandom_range(1));
                    addr1  = rnd64();
                    wdata1 = rnd64();
                end
            end else if (!(act && own) && $urandom_range(15) == 0) begin
                req1 = 1'b0;
            end
        end
        en_e   = act && ph <= lat;
        lastb  = act && ph == lat;
        ack0_e = act && ph == lat + 1 && !own;
        ack1_e = act && ph == lat + 1 && own;
        // Memory data is valid only in the last BUSY cycle; noise elsewhere.
        mem_rdata = (lastb && !we_l) ? memfn(addr_l) : rnd64();
        @(negedge clk);
        chk("mem_en", 64'(o_en), 64'(en_e));
        chk("mem_we", 64'(o_we), 64'(en_e && we_l));
        chk("ack0", 64'(o_ack0), 64'(ack0_e));
        chk("ack1", 64'(o_ack1), 64'(ack1_e));
        chk("mux_sel", 64'(o_sel), 64'(sel_e));
        chk("mem_addr", o_addr, addr_l);
        chk("mem_wdata", o_wdata, wdata_l);
        if (ack0_e || ack1_e) chk("rdata", o_rdata, rdata_e);
        if (o_ack0 === 1'b1) begin ack_p.push_back(0); ack_t.push_back(cyc); end
        if (o_ack1 === 1'b1) begin ack_p.push_back(1); ack_t.push_back(cyc); end
    endtask

    initial begin
        lat = 2;
        use_b = 1'b0;
        do_reset();

        // Single fetch from 0x100.
        clear_log();
        addr0 = 64'h100;
        req0  = 1'b1;
        repeat (6) cycle();
        chk("fetch_ack_count", 64'(ack_p.size()), 64'(1));
        if (ack_p.size() > 0) begin
            chk("fetch_ack_port", 64'(ack_p[0]), 64'(0));
            chk("fetch_ack_cycle", 64'(ack_t[0]), 64'(3));
        end
        chk("fetch_rdata_hold", o_rdata, 64'hDEAD);

        // Data write; rdata must keep the fetched value.
        clear_log();
        we1 = 1'b1; addr1 = 64'h2000; wdata1 = 64'h55; req1 = 1'b1;
        repeat (6) cycle();
        we1 = 1'b0;
        chk("write_ack_count", 64'(ack_p.size()), 64'(1));
        if (ack_p.size() > 0) chk("write_ack_port", 64'(ack_p[0]), 64'(1));
        chk("write_rdata_kept", o_rdata, 64'hDEAD);

        // Continuous tie from reset: grants 1,0,1,0, one every LAT+2 cycles.
        do_reset();
        clear_log();
        hold0 = 1'b1; hold1 = 1'b1;
        addr0 = rnd64(); addr1 = rnd64(); wdata1 = rnd64();
        req0 = 1'b1; req1 = 1'b1;
        repeat (16) cycle();
        chk("tie_ack_count", 64'(ack_p.size()), 64'(4));
        for (int i = 0; i < 4 && i < ack_p.size(); i++) begin
            chk("tie_ack_port", 64'(ack_p[i]), 64'((i % 2 == 0) ? 1 : 0));
            chk("tie_ack_cycle", 64'(ack_t[i]), 64'(3 + 4 * i));
        end
        hold0 = 1'b0; hold1 = 1'b0;
        repeat (12) cycle();

        // Reset one cycle into BUSY: no ack, then pending port 1 wins the tie.
        addr0 = rnd64();
        req0  = 1'b1;
        cycle();
        cycle();
        req1 = 1'b1; addr1 = rnd64(); wdata1 = rnd64();
        do_reset();
        clear_log();
        repeat (12) cycle();
        chk("rst_busy_ack_count", 64'(ack_p.size()), 64'(2));
        if (ack_p.size() > 1) begin
            chk("rst_busy_first_port", 64'(ack_p[0]), 64'(1));
            chk("rst_busy_second_port", 64'(ack_p[1]), 64'(0));
        end

        // Requester drops req0 right after grant: still completes.
        clear_log();
        addr0 = rnd64();
        req0  = 1'b1;
        cycle();
        req0 = 1'b0;
        repeat (8) cycle();
        chk("drop_ack_count", 64'(ack_p.size()), 64'(1));
        if (ack_p.size() > 0) chk("drop_ack_cycle", 64'(ack_t[0]), 64'(3));

        // Random traffic, LAT=2.
        rnd = 1'b1;
        repeat (400) cycle();
        rnd = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (8) cycle();

        // LAT=1 build: back-to-back fetches every 3 cycles.
        use_b = 1'b1;
        lat   = 1;
        do_reset();
        clear_log();
        hold0 = 1'b1;
        addr0 = rnd64();
        req0  = 1'b1;
        repeat (10) cycle();
        chk("lat1_ack_count", 64'(ack_p.size()), 64'(3));
        for (int i = 0; i < 3 && i < ack_p.size(); i++) begin
            chk("lat1_ack_cycle", 64'(ack_t[i]), 64'(2 + 3 * i));
        end
        hold0 = 1'b0;
        repeat (6) cycle();

        // Random traffic, LAT=1.
        rnd = 1'b1;
        repeat (300) cycle();
        rnd = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (6) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for a single shared 64-bit memory port.
- Port 0 is instruction fetch (read-only); port 1 is data access (read/write).
- Grants one requester at a time and latches its address and write data.
- Drives the select line of the existing 64-bit 2:1 address mux, sequences a fixed-latency memory access, and returns read data with a one-cycle acknowledge.

Parameters:
- WIDTH, 64, address/data width in bits.
- LAT, 2, memory access latency in cycles (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  fetch request; held high until ack0.
- addr0  input  WIDTH  fetch address; stable while req0 high.
- req1  input  1  data request; held high until ack1.
- we1  input  1  1 = write, 0 = read; stable while req1 high.
- addr1  input  WIDTH  data address; stable while req1 high.
- wdata1  input  WIDTH  write data.
- ack0  output  1  one-cycle pulse: fetch transaction complete.
- ack1  output  1  one-cycle pulse: data transaction complete.
- rdata  output  WIDTH  read data; valid only while ack0 or ack1 is high.
- mux_sel  output  1  granted port index; drives the address mux select.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  WIDTH  latched address to memory.
- mem_wdata  output  WIDTH  latched write data to memory.
- mem_rdata  input  WIDTH  memory read data; valid in the last BUSY cycle.

Behaviour:
- Reset values: state IDLE; ack0/ack1/mem_en/mem_we = 0; mux_sel = 0; mem_addr, mem_wdata, rdata = 0; last_grant = 0; counter = 0.
- Reset mid-transaction:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - The in-flight access is abandoned and no ack is issued.
- State IDLE:
  - Samples req0/req1 on each rising edge.
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port not equal to last_grant (round-robin). After reset, port 1 wins the first tie.
  - On grant, at the same edge:
    - mux_sel <= granted index; last_grant <= granted index.
    - mem_addr <= addr of granted port.
    - mem_wdata <= wdata1 if port 1, else 0.
    - Latch we = we1 & (grant==1).
    - counter <= LAT-1; state -> BUSY.
- State BUSY:
  - mem_en = 1; mem_we = latched we; mem_addr and mem_wdata held.
  - Each edge: if counter != 0, decrement.
  - If counter == 0: rdata <= mem_rdata (for reads; rdata holds its prior value for writes); state -> RESP.
  - BUSY lasts exactly LAT cycles.
- State RESP:
  - mem_en = 0, mem_we = 0.
  - ack[mux_sel] = 1 for exactly one cycle; the other ack stays 0.
  - Requests are ignored in this state. Next state is IDLE.
  - The requester drops req on the edge that ends RESP.
- Timing:
  - Request sampled at edge k → BUSY for cycles k+1..k+LAT → ack in cycle k+LAT+1 → IDLE at k+LAT+2.
  - Back-to-back throughput is one transaction per LAT+2 cycles.
- Outputs ack*, mem_en and mem_we are decoded from registered state only, so they are glitch-free.
- mux_sel is held through BUSY and RESP and changes only on a new grant.
- A request that drops before its grant is simply not served.
- A request that drops after its grant still completes and acks; the requester ignores that ack.
- we1 is ignored when port 0 is granted. Port 0 never writes.
- LAT = 1: BUSY lasts a single cycle; rdata is captured at the end of that cycle.

Test Plan:
- Reset then single fetch: assert reset, release; req0=1, addr0=0x100, LAT=2, memory returns 0xDEAD → mem_en high 2 cycles with mem_addr=0x100, mux_sel=0; ack0 pulses in cycle 4 after request with rdata=0xDEAD; ack1 never asserts.
- Data write: req1=1, we1=1, addr1=0x2000, wdata1=0x55 → mem_we=1 and mem_wdata=0x55 for both BUSY cycles, mux_sel=1; ack1 pulses once; rdata keeps its prior value.
- Simultaneous requests held continuously:
  - From reset, req0=req1=1 → grants in order 1,0,1,0.
  - Each ack arrives 4 cycles apart (LAT=2).
  - mux_sel toggles only at grant edges.
- Asynchronous reset mid-BUSY:
  - Assert reset one cycle into BUSY → mem_en drops the same cycle; no ack is ever issued.
  - After release, a pending req1 wins the tie (last_grant=0).
- LAT=1 build, back-to-back reads on port 0 → mem_en high 1 cycle per transaction; ack0 every 3 cycles; rdata matches per-address memory model.
- Requester drops req0 one cycle after grant → transaction still completes; ack0 pulses; arbiter returns to IDLE and is idle with no further mem_en.
